cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Execution sequencer for the single-cycle CPU on the board.
- Produces a one-cycle CPU clock-enable pulse from the divided tick.
- Supports free-run, pause, single-step from a push-button, and halt on a PC breakpoint.
- Counts retired instructions for the 7-segment display mux.
- Sits between the clock dividers/switches and the SCPU clock-enable; the CPU's PC is fed back in for breakpoint compare.

Parameters:
DEB_CYCLES, 16, consecutive stable clk cycles required to accept a new step-button level
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock (single clock domain)
rst  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide pulse from the divider; the run-rate time base
run_sw  input  1  level switch; 1 = run, 0 = pause
step_btn  input  1  raw, asynchronous push-button; bounces
bp_en  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC (byte address)
pc  input  32  current CPU PC
cpu_ce  output  1  registered CPU clock-enable; one instruction retires per high cycle
state_o  output  2  FSM state encoding: PAUSE=0, RUN=1, STEP=2, BREAK=3
bp_hit  output  1  high while in BREAK
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, active-high) values: state=PAUSE, cpu_ce=0, bp_hit=0, instr_cnt=0, synchronizer/debounce state=0, skip flag=0.
- Reset mid-run aborts any pending enable immediately.
- Step input path:
  - step_btn passes through a 2-FF synchronizer.
  - The debounced level changes only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles.
  - A debounced 0->1 transition yields step_p, one cycle wide. A button held down produces no repeats.
- cpu_ce is registered. It rises the cycle after an accepted tick and is high for exactly one cycle.
- FSM, transitions evaluated each clk:
  - PAUSE:
    - step_p -> STEP.
    - Else run_sw=1 -> RUN, and set skip=1.
    - Ticks are ignored.
  - RUN:
    - run_sw=0 -> PAUSE (takes priority over a coincident tick).
    - Else on tick: if bp_en=1, pc==bp_addr and skip=0 -> BREAK, with no enable. Otherwise issue cpu_ce next cycle and clear skip.
    - step_p is ignored.
  - STEP:
    - On the first tick -> issue cpu_ce next cycle and go to PAUSE.
    - The breakpoint is not checked.
    - run_sw is ignored until the step completes.
  - BREAK:
    - bp_hit=1, cpu_ce=0.
    - step_p -> STEP. This executes the breakpointed instruction.
    - run_sw=0 -> PAUSE.
    - Resuming requires run_sw 0 then 1. The skip flag then lets the breakpointed instruction retire once.
- skip flag:
  - Set on entry to RUN.
  - Cleared when RUN issues its first enable.
  - Guarantees forward progress past a breakpoint.
- Simultaneous events:
  - In PAUSE, step_p and tick in the same cycle: enter STEP; that tick is not consumed, so the step executes on the next tick.
  - In PAUSE, step_p and run_sw=1: step wins.
- instr_cnt increments by 1 in each cycle where cpu_ce=1, and saturates at all-ones (no wrap).
- PC compare is a full 32-bit equality; no masking.
- Throughput: at most one enable per tick. Enable latency from tick is 1 clk.

Decomposition:
- Shared package/macro header holds:
  - state encodings PAUSE/RUN/STEP/BREAK (2-bit);
  - default DEB_CYCLES.
- One sub-module is natural: btn_debounce. It contains the synchronizer, debounce counter and rising-edge pulse, with parameter DEB_CYCLES and ports clk, rst, btn_in, level_o, rise_p. It is reusable for other board buttons.

Test Plan:
- Reset then run_sw=1, bp_en=0, 5 ticks spaced 10 clk -> 5 cpu_ce pulses, each 1 clk after its tick; instr_cnt=5; state_o=1.
- PAUSE, step_btn bouncing 0/1 every 3 clk for 12 clk then held 1 for 40 clk (DEB_CYCLES=16) -> exactly one step_p; the next tick gives one cpu_ce; state returns to 0; instr_cnt +1.
- RUN with bp_en=1, bp_addr=0x0000_0010, pc stepping 0x0,0x4,... -> enables at pc 0x0..0xC, then the tick at pc 0x10 gives no cpu_ce; state_o=3, bp_hit=1, instr_cnt=4.
- From BREAK: run_sw 0 then 1 -> the first tick retires 0x10 despite the match; pc 0x14 follows. Alternatively step_p in BREAK -> a single enable, then PAUSE.
- PAUSE with step_p and tick in the same cycle -> no cpu_ce that cycle; cpu_ce follows the next tick. RUN with run_sw falling on the same cycle as a tick -> no cpu_ce; state PAUSE.
- CNT_W=4, run 17 ticks -> instr_cnt saturates at 0xF. Assert rst mid-RUN in the cycle after a tick -> cpu_ce, instr_cnt and state all immediately 0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU execution sequencer: state encodings and defaults.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_o,
  output logic rise_p
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      level_o <= 1'b0;
      rise_p  <= 1'b0;
    end else begin
      rise_p <= 1'b0;
      if (sync2 != level_o) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level_o <= sync2;
          rise_p  <= sync2;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: free-run, pause, single-step and PC breakpoint control of the CPU clock-enable.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_ce,
  output logic [1:0]       state_o,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  run_state_t state;
  run_state_t state_n;
  logic       skip;
  logic       skip_n;
  logic       ce_n;
  logic       step_level;
  logic       step_rise;
  logic       step_p;
  logic       bp_match;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk    (clk),
    .rst    (rst),
    .btn_in (step_btn),
    .level_o(step_level),
    .rise_p (step_rise)
  );

  assign step_p   = step_rise & step_level;
  assign bp_match = bp_en && (pc == bp_addr) && !skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_PAUSE;
      skip   <= 1'b0;
      cpu_ce <= 1'b0;
    end else begin
      state  <= state_n;
      skip   <= skip_n;
      cpu_ce <= ce_n;
    end
  end

  // A tick is only consumed in RUN or STEP; in PAUSE/BREAK it is dropped.
  always_comb begin
    state_n = state;
    skip_n  = skip;
    ce_n    = 1'b0;
    case (state)
      ST_PAUSE: begin
        if (step_p) begin
          state_n = ST_STEP;
        end else if (run_sw) begin
          state_n = ST_RUN;
          skip_n  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_n = ST_PAUSE;
        end else if (tick) begin
          if (bp_match) begin
            state_n = ST_BREAK;
          end else begin
            ce_n   = 1'b1;
            skip_n = 1'b0;
          end
        end
      end
      ST_STEP: begin
        if (tick) begin
          ce_n    = 1'b1;
          state_n = ST_PAUSE;
        end
      end
      ST_BREAK: begin
        if (step_p) begin
          state_n = ST_STEP;
        end else if (!run_sw) begin
          state_n = ST_PAUSE;
        end
      end
      default: state_n = ST_PAUSE;
    endcase
  end

  // Saturating retired-instruction counter; the display must never wrap to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (cpu_ce && (instr_cnt != {CNT_W{1'b1}})) begin
      instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state_o = state;
  assign bp_hit  = (state == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected enables queued at stimulus time, checked by a monitor.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic [1:0]  state_o;
  logic        bp_hit;
  logic [31:0] instr_cnt;

  logic        tick_s;
  logic        run_sw_s;
  logic        zero_s;
  logic [31:0] zero32_s;
  logic        cpu_ce_s;
  logic [1:0]  state_s;
  logic        bp_hit_s;
  logic [3:0]  instr_cnt_s;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_run_ctrl #(.DEB_CYCLES(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .cpu_ce   (cpu_ce),
    .state_o  (state_o),
    .bp_hit   (bp_hit),
    .instr_cnt(instr_cnt)
  );

  cpu_run_ctrl #(.DEB_CYCLES(16), .CNT_W(4)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick_s),
    .run_sw   (run_sw_s),
    .step_btn (zero_s),
    .bp_en    (zero_s),
    .bp_addr  (zero32_s),
    .pc       (zero32_s),
    .cpu_ce   (cpu_ce_s),
    .state_o  (state_s),
    .bp_hit   (bp_hit_s),
    .instr_cnt(instr_cnt_s)
  );

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle tick; when an enable is expected, queue the cycle, pc and count it must show.
  task automatic applyStimulus(input logic do_tick, input logic expect_ce, input int gap);
    exp_t e;
    tick = do_tick;
    if (expect_ce) begin
      e.cyc = cyc + 1;
      e.pc  = pc;
      e.cnt = exp_cnt;
      sb.push_back(e);
      exp_cnt = exp_cnt + 1;
    end
    wait_clk();
    tick = 1'b0;
    repeat (gap) wait_clk();
  endtask

  always @(negedge clk) begin
    if (!rst && cpu_ce) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ce: cyc=%0d pc=%0h cnt=%0h, no enable queued", cyc, pc, instr_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || pc !== e.pc || instr_cnt !== e.cnt) begin
          errors++;
          $display("[TB] FAIL ce_pulse: got cyc=%0d pc=%0h cnt=%0h expected cyc=%0d pc=%0h cnt=%0h",
                   cyc, pc, instr_cnt, e.cyc, e.pc, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
    tick_s = 1'b0; run_sw_s = 1'b1; zero_s = 1'b0; zero32_s = 32'h0;
    repeat (3) wait_clk();
    checkOutput("reset_state", {30'd0, state_o}, 32'd0);
    checkOutput("reset_ce", {31'd0, cpu_ce}, 32'd0);
    checkOutput("reset_bp_hit", {31'd0, bp_hit}, 32'd0);
    checkOutput("reset_cnt", instr_cnt, 32'd0);
    rst = 1'b0;
    wait_clk();

    $display("[TB] free run, 5 ticks");
    run_sw = 1'b1;
    repeat (2) wait_clk();
    for (int i = 0; i < 5; i++) begin
      pc = 32'h100 + 32'(4 * i);
      applyStimulus(1'b1, 1'b1, 9);
    end
    checkOutput("run_cnt", instr_cnt, 32'd5);
    checkOutput("run_state", {30'd0, state_o}, 32'(ST_RUN));

    $display("[TB] bouncing step button");
    run_sw = 1'b0;
    repeat (2) wait_clk();
    checkOutput("pause_state", {30'd0, state_o}, 32'(ST_PAUSE));
    for (int k = 0; k < 4; k++) begin
      step_btn = ~step_btn;
      repeat (3) wait_clk();
    end
    checkOutput("bounce_no_step", {30'd0, state_o}, 32'(ST_PAUSE));
    step_btn = 1'b1;
    repeat (40) wait_clk();
    checkOutput("debounced_step", {30'd0, state_o}, 32'(ST_STEP));
    pc = 32'h200;
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("step_done_state", {30'd0, state_o}, 32'(ST_PAUSE));
    checkOutput("step_cnt", instr_cnt, 32'd6);
    repeat (20) wait_clk();
    checkOutput("held_no_repeat", {30'd0, state_o}, 32'(ST_PAUSE));
    step_btn = 1'b0;
    repeat (25) wait_clk();

    $display("[TB] breakpoint at 0x10");
    bp_en = 1'b1; bp_addr = 32'h10;
    run_sw = 1'b1;
    repeat (2) wait_clk();
    for (int i = 0; i < 4; i++) begin
      pc = 32'(4 * i);
      applyStimulus(1'b1, 1'b1, 4);
    end
    pc = 32'h10;
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("bp_state", {30'd0, state_o}, 32'(ST_BREAK));
    checkOutput("bp_hit", {31'd0, bp_hit}, 32'd1);
    checkOutput("bp_cnt", instr_cnt, 32'd10);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("bp_hold", {30'd0, state_o}, 32'(ST_BREAK));

    $display("[TB] resume from break via run_sw");
    run_sw = 1'b0;
    repeat (2) wait_clk();
    checkOutput("bp_to_pause", {30'd0, state_o}, 32'(ST_PAUSE));
    run_sw = 1'b1;
    repeat (2) wait_clk();
    applyStimulus(1'b1, 1'b1, 4);
    pc = 32'h14;
    applyStimulus(1'b1, 1'b1, 4);
    checkOutput("resume_cnt", instr_cnt, 32'd12);
    checkOutput("resume_state", {30'd0, state_o}, 32'(ST_RUN));

    $display("[TB] step out of break");
    pc = 32'h10;
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("bp_again", {30'd0, state_o}, 32'(ST_BREAK));
    step_btn = 1'b1;
    repeat (25) wait_clk();
    checkOutput("bp_step_state", {30'd0, state_o}, 32'(ST_STEP));
    applyStimulus(1'b1, 1'b1, 0);
    checkOutput("bp_step_pause", {30'd0, state_o}, 32'(ST_PAUSE));
    run_sw = 1'b0;
    step_btn = 1'b0;
    repeat (25) wait_clk();
    checkOutput("bp_step_cnt", instr_cnt, 32'd13);

    $display("[TB] step pulse coincident with tick");
    bp_en = 1'b0;
    pc = 32'h300;
    step_btn = 1'b1;
    repeat (18) wait_clk();
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("coincide_step", {30'd0, state_o}, 32'(ST_STEP));
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("coincide_pause", {30'd0, state_o}, 32'(ST_PAUSE));
    step_btn = 1'b0;
    repeat (25) wait_clk();

    $display("[TB] run_sw falling with tick");
    run_sw = 1'b1;
    repeat (2) wait_clk();
    run_sw = 1'b0;
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("fall_state", {30'd0, state_o}, 32'(ST_PAUSE));
    checkOutput("fall_cnt", instr_cnt, 32'd14);

    $display("[TB] reset mid-run");
    run_sw = 1'b1;
    repeat (2) wait_clk();
    tick = 1'b1;
    wait_clk();
    tick = 1'b0;
    checkOutput("pre_reset_ce", {31'd0, cpu_ce}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_ce", {31'd0, cpu_ce}, 32'd0);
    checkOutput("mid_reset_cnt", instr_cnt, 32'd0);
    checkOutput("mid_reset_state", {30'd0, state_o}, 32'(ST_PAUSE));
    exp_cnt = 32'd0;
    run_sw = 1'b0;
    wait_clk();
    rst = 1'b0;
    repeat (3) wait_clk();

    $display("[TB] 4-bit counter saturation");
    for (int i = 0; i < 17; i++) begin
      tick_s = 1'b1;
      wait_clk();
      tick_s = 1'b0;
      repeat (3) wait_clk();
      if (i == 13) checkOutput("sat_cnt_14", {28'd0, instr_cnt_s}, 32'd14);
    end
    checkOutput("sat_cnt_max", {28'd0, instr_cnt_s}, 32'hF);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
